// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the pipeline. Owns the architectural PC and hands
// pc + 4 back to the PC select mux. Fetches over a req/gnt/rvalid
// instruction-memory handshake with at most one request outstanding, and
// loads the IF/ID pipeline register while obeying stall and flush from the
// hazard and branch logic.
//
// Parameters:
//   RESET_PC     PC loaded on reset. The low two bits are masked off.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   next_pc      in   32  next PC from the PC select mux (branch target or pc4)
//   pc4          out  32  pc + 4, combinational, back to the PC select mux
//   stall        in   1   ID is stalled; IF/ID must hold
//   flush        in   1   redirect; discard in-flight and buffered instruction
//   imem_req     out  1   fetch request valid (only in FETCH)
//   imem_addr    out  32  fetch address (the current pc)
//   imem_gnt     in   1   request accepted this cycle
//   imem_rvalid  in   1   read data valid
//   imem_rdata   in   32  instruction word
//   if_pc        out  32  IF/ID PC
//   if_inst      out  32  IF/ID instruction
//   if_valid     out  1   IF/ID valid
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  output logic [31:0] pc4,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  // FETCH: request presented.  WAIT: granted, waiting for data.
  // HOLD: data returned while ID was stalled, parked in the hold buffer.
  // DROP: a flushed request is still outstanding; its data must be thrown away.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] hold_pc;
  logic [31:0] hold_pc_nxt;
  logic [31:0] hold_inst;
  logic [31:0] hold_inst_nxt;
  logic [31:0] if_pc_nxt;
  logic [31:0] if_inst_nxt;
  logic        if_valid_nxt;
  logic [31:0] next_pc_aligned;

  // Instructions are word aligned, so the low PC bits are never stored even
  // if the mux hands us a misaligned target.
  assign next_pc_aligned = next_pc & PC_ALIGN_MASK;

  assign pc4       = pc + 32'd4;
  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC_ALIGNED;
      hold_pc   <= 32'h0000_0000;
      hold_inst <= 32'h0000_0000;
      if_pc     <= 32'h0000_0000;
      if_inst   <= NOP_INST;
      if_valid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      hold_pc   <= hold_pc_nxt;
      hold_inst <= hold_inst_nxt;
      if_pc     <= if_pc_nxt;
      if_inst   <= if_inst_nxt;
      if_valid  <= if_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    hold_pc_nxt   = hold_pc;
    hold_inst_nxt = hold_inst;
    if_pc_nxt     = if_pc;
    if_inst_nxt   = if_inst;
    // With nothing delivered, a stalled IF/ID keeps its contents while an
    // unstalled one turns into a bubble (pc/inst left as they were).
    if_valid_nxt  = stall ? if_valid : 1'b0;

    if (flush) begin
      // Flush outranks stall: redirect the PC, kill IF/ID and the hold
      // buffer, and remember whether a response is still owed by memory.
      pc_nxt        = next_pc_aligned;
      if_valid_nxt  = 1'b0;
      hold_pc_nxt   = 32'h0000_0000;
      hold_inst_nxt = 32'h0000_0000;
      case (state)
        ST_FETCH: state_nxt = imem_gnt    ? ST_DROP  : ST_FETCH;
        ST_WAIT:  state_nxt = imem_rvalid ? ST_FETCH : ST_DROP;
        ST_HOLD:  state_nxt = ST_FETCH;
        ST_DROP:  state_nxt = imem_rvalid ? ST_FETCH : ST_DROP;
        default:  state_nxt = ST_FETCH;
      endcase
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_gnt) begin
            state_nxt = ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (imem_rvalid) begin
            if (stall) begin
              // ID cannot take it yet; park it so memory is free again.
              hold_pc_nxt   = pc;
              hold_inst_nxt = imem_rdata;
              state_nxt     = ST_HOLD;
            end else begin
              if_pc_nxt    = pc;
              if_inst_nxt  = imem_rdata;
              if_valid_nxt = 1'b1;
              pc_nxt       = next_pc_aligned;
              state_nxt    = ST_FETCH;
            end
          end
        end

        ST_HOLD: begin
          if (!stall) begin
            if_pc_nxt    = hold_pc;
            if_inst_nxt  = hold_inst;
            if_valid_nxt = 1'b1;
            pc_nxt       = next_pc_aligned;
            state_nxt    = ST_FETCH;
          end
        end

        ST_DROP: begin
          if (imem_rvalid) begin
            state_nxt = ST_FETCH;
          end
        end

        default: begin
          state_nxt = ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage consuming next_pc from the PC select mux.
- Holds the architectural PC and returns pc4 to the mux.
- Issues instruction-memory requests over a req/gnt/rvalid handshake with at most one request outstanding.
- Drives the IF/ID pipeline register, honouring stall and flush from the hazard/branch logic.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
next_pc  input  32  next PC from PC select mux (branch target or pc4)
pc4  output  32  pc + 4, combinational, to PC select mux
stall  input  1  ID stalled; IF/ID must hold
flush  input  1  redirect: discard in-flight and buffered instruction
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (= pc)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
if_pc  output  32  IF/ID PC
if_inst  output  32  IF/ID instruction
if_valid  output  1  IF/ID valid

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH.
  - if_pc=0, if_inst=32'h0000_0013 (NOP), if_valid=0.
  - Hold buffer cleared.
- Arithmetic:
  - pc4 = pc + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - pc[1:0] forced to 00 on every load; next_pc[1:0] ignored.
- imem_req=1 only in FETCH; imem_addr=pc whenever imem_req=1, else don't-care.
- States:
  - FETCH: req=1. gnt=1 -> WAIT. gnt=0 -> stay.
  - WAIT: awaiting rvalid.
    - rvalid=1, stall=0: IF/ID <= {pc, rdata, 1}; pc <= next_pc; -> FETCH.
    - rvalid=1, stall=1: hold buffer <= {pc, rdata}; -> HOLD.
    - rvalid=0: stay.
  - HOLD: buffered instruction waiting for ID.
    - stall=0: IF/ID <= hold buffer with valid=1; pc <= next_pc; -> FETCH.
  - DROP: a flushed request is still outstanding. rvalid=1 -> response discarded; -> FETCH.
- IF/ID update rules:
  - stall=1: if_* hold their value.
  - stall=0 and no instruction delivered this cycle: if_valid <= 0 (bubble); if_pc and if_inst hold.
- Latency: req at cycle N with gnt, rvalid at N+k -> if_valid=1 at N+k+1. Best-case throughput is one instruction per 2 cycles.
- pc changes only on acceptance (WAIT rvalid with stall=0, HOLD exit) or on flush. next_pc is sampled in that same cycle.
- Flush has priority over stall and everything else:
  - pc <= next_pc and if_valid <= 0 next cycle; hold buffer invalidated.
  - FETCH, gnt=0: -> FETCH; the new address is presented next cycle.
  - FETCH, gnt=1: -> DROP.
  - WAIT, rvalid=1: data discarded; -> FETCH.
  - WAIT, rvalid=0: -> DROP.
  - HOLD: -> FETCH.
  - DROP: -> DROP, or -> FETCH if rvalid=1 the same cycle.
- An rvalid that arrives in FETCH or HOLD is a protocol error and is ignored. A bench assertion flags it.
- Reset mid-operation: state returns to FETCH immediately. Any later stray rvalid is ignored per the rule above.

Test Plan:
- Reset release, RESET_PC=0, next_pc tied to pc4, gnt=1, rvalid 1 cycle after gnt, rdata=0x00A00093:
  - first imem_addr=0x0, then 0x4, 0x8.
  - if_valid pulses every 2nd cycle with if_pc=0x0, 0x4, ...
- stall=1 asserted when the rvalid for pc=0x8 arrives, held 3 cycles:
  - if_* unchanged for 3 cycles; imem_req=0.
  - After release: if_pc=0x8, if_valid=1 for 1 cycle, then fetch of 0xC.
- flush=1 with next_pc=0x100 while in WAIT (rvalid not yet returned):
  - late response is discarded; if_valid stays 0.
  - next imem_addr=0x100; next if_pc=0x100.
- flush and stall both high in HOLD, next_pc=0x200:
  - if_valid=0 next cycle; the held instruction never appears; next fetch addr=0x200.
- pc=0xFFFF_FFFC: pc4=0x0000_0000; after acceptance the next imem_addr=0x0.
- rst_n pulsed low in WAIT: all outputs return to reset values asynchronously; after release the first imem_addr=RESET_PC.
